// File: rtl/otg_hpi_io_engine.sv
// -----------------------------------------------------------------------------
// otg_hpi_io_engine
//
// Avalon-MM slave that turns one Nios II read or write into a complete
// CY7C67200 HPI bus cycle with hardware-timed setup/strobe/hold/recovery.
// The 4-word window maps 1:1 onto the HPI registers: 0 data, 1 mailbox,
// 2 address, 3 status.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   avs_address[1:0]        HPI register select
//   avs_chipselect/read/write, avs_writedata[15:0]   Avalon request
//   avs_readdata[15:0]      registered read data, valid in the completion cycle
//   avs_waitrequest         combinational stall
//   hpi_addr[1:0], hpi_data_out[15:0], hpi_data_oe, hpi_cs_n, hpi_rd_n,
//   hpi_wr_n                registered HPI pin drivers (tri-state lives above)
//   hpi_data_in[15:0]       HPI data from pins, already synchronous to clk
//   busy                    high whenever the engine is not idle
// -----------------------------------------------------------------------------
module otg_hpi_io_engine #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4,
        RECOVER = 3'd5
    } state_t;

    // Counter reload values are "cycles - 1"; a zero parameter on a
    // minimum-one phase behaves like one.
    localparam logic [7:0] SETUP_LOAD   = (SETUP_CYCLES    > 1) ? 8'(SETUP_CYCLES    - 1) : 8'd0;
    localparam logic [7:0] STROBE_LOAD  = (STROBE_CYCLES   > 1) ? 8'(STROBE_CYCLES   - 1) : 8'd0;
    localparam logic [7:0] HOLD_LOAD    = (HOLD_CYCLES     > 1) ? 8'(HOLD_CYCLES     - 1) : 8'd0;
    localparam logic [7:0] RECOVER_LOAD = (RECOVERY_CYCLES > 1) ? 8'(RECOVERY_CYCLES - 1) : 8'd0;
    localparam logic       HAS_RECOVER  = (RECOVERY_CYCLES > 0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  addr_lat_q, addr_lat_d;
    logic [15:0] data_lat_q, data_lat_d;
    logic        wr_lat_q, wr_lat_d;
    logic [15:0] readdata_q, readdata_d;
    logic [1:0]  hpi_addr_q, hpi_addr_d;
    logic [15:0] hpi_data_out_q, hpi_data_out_d;
    logic        hpi_data_oe_q, hpi_data_oe_d;
    logic        hpi_cs_n_q, hpi_cs_n_d;
    logic        hpi_rd_n_q, hpi_rd_n_d;
    logic        hpi_wr_n_q, hpi_wr_n_d;
    logic        req_s;
    logic        active_d;

    assign req_s = avs_chipselect & (avs_read | avs_write);

    // Next-state, phase counter, request latch and read capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_lat_d = addr_lat_q;
        data_lat_d = data_lat_q;
        wr_lat_d   = wr_lat_q;
        readdata_d = readdata_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_lat_d = avs_address;
                    data_lat_d = avs_writedata;
                    // A simultaneous read+write is carried out as a write.
                    wr_lat_d   = avs_write;
                    cnt_d      = SETUP_LOAD;
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                    // Sample the pins on the edge that releases the strobe.
                    if (!wr_lat_q) begin
                        readdata_d = hpi_data_in;
                    end else begin
                        readdata_d = readdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (HAS_RECOVER) begin
                    cnt_d   = RECOVER_LOAD;
                    state_d = RECOVER;
                end else begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin drivers are derived from the upcoming state so that the registered
    // outputs line up with the state they belong to.
    always_comb begin
        active_d       = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        hpi_cs_n_d     = !active_d;
        hpi_rd_n_d     = !((state_d == STROBE) && !wr_lat_d);
        hpi_wr_n_d     = !((state_d == STROBE) && wr_lat_d);
        hpi_data_oe_d  = active_d && wr_lat_d;
        hpi_addr_d     = active_d ? addr_lat_d : 2'd0;
        hpi_data_out_d = hpi_data_oe_d ? data_lat_d : 16'd0;
    end

    // State and output registers; reset forces every strobe inactive at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            addr_lat_q     <= 2'd0;
            data_lat_q     <= 16'd0;
            wr_lat_q       <= 1'b0;
            readdata_q     <= 16'd0;
            hpi_addr_q     <= 2'd0;
            hpi_data_out_q <= 16'd0;
            hpi_data_oe_q  <= 1'b0;
            hpi_cs_n_q     <= 1'b1;
            hpi_rd_n_q     <= 1'b1;
            hpi_wr_n_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_lat_q     <= addr_lat_d;
            data_lat_q     <= data_lat_d;
            wr_lat_q       <= wr_lat_d;
            readdata_q     <= readdata_d;
            hpi_addr_q     <= hpi_addr_d;
            hpi_data_out_q <= hpi_data_out_d;
            hpi_data_oe_q  <= hpi_data_oe_d;
            hpi_cs_n_q     <= hpi_cs_n_d;
            hpi_rd_n_q     <= hpi_rd_n_d;
            hpi_wr_n_q     <= hpi_wr_n_d;
        end
    end

    assign avs_readdata    = readdata_q;
    assign avs_waitrequest = req_s & (state_q != DONE);
    assign busy            = (state_q != IDLE);
    assign hpi_addr        = hpi_addr_q;
    assign hpi_data_out    = hpi_data_out_q;
    assign hpi_data_oe     = hpi_data_oe_q;
    assign hpi_cs_n        = hpi_cs_n_q;
    assign hpi_rd_n        = hpi_rd_n_q;
    assign hpi_wr_n        = hpi_wr_n_q;

endmodule

// File: tb/tb_otg_hpi_io_engine.sv
// -----------------------------------------------------------------------------
// Directed bench for otg_hpi_io_engine with default timing parameters.
// Cycle n runs from rising edge n to rising edge n+1; inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_otg_hpi_io_engine;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        busy;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic        exp_write;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    otg_hpi_io_engine dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_chipselect  (avs_chipselect),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .hpi_addr        (hpi_addr),
        .hpi_data_out    (hpi_data_out),
        .hpi_data_oe     (hpi_data_oe),
        .hpi_data_in     (hpi_data_in),
        .hpi_cs_n        (hpi_cs_n),
        .hpi_rd_n        (hpi_rd_n),
        .hpi_wr_n        (hpi_wr_n),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = 2'd0;
        avs_writedata  = 16'd0;
        hpi_data_in    = 16'd0;
    endtask

    // One complete transfer, request raised in cycle 0 and held until DONE.
    task automatic run_txn(input vec_t v);
        logic strobe_c;
        logic active_c;
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin
                avs_chipselect = 1'b1;
                avs_read       = v.rd;
                avs_write      = v.wr;
                avs_address    = v.addr;
                avs_writedata  = v.wdata;
            end
            if (c == 8) begin
                idle_inputs();
            end
            hpi_data_in = (c >= 2 && c <= 5) ? v.din : 16'h0000;
            @(negedge clk);
            strobe_c = (c >= 2 && c <= 5);
            active_c = (c >= 1 && c <= 6);
            check("waitrequest", c, {31'd0, avs_waitrequest}, {31'd0, (c < 7)});
            check("cs_n",        c, {31'd0, hpi_cs_n},   {31'd0, !active_c});
            check("wr_n",        c, {31'd0, hpi_wr_n},   {31'd0, !(strobe_c && v.exp_write)});
            check("rd_n",        c, {31'd0, hpi_rd_n},   {31'd0, !(strobe_c && !v.exp_write)});
            check("data_oe",     c, {31'd0, hpi_data_oe}, {31'd0, (active_c && v.exp_write)});
            check("busy",        c, {31'd0, busy},       {31'd0, (c >= 1 && c <= 9)});
            if (active_c) begin
                check("hpi_addr", c, {30'd0, hpi_addr}, {30'd0, v.addr});
                if (v.exp_write) begin
                    check("hpi_data_out", c, {16'd0, hpi_data_out}, {16'd0, v.wdata});
                end
            end
            if (c == 7) begin
                check("readdata", c, {16'd0, avs_readdata}, {16'd0, v.exp_rdata});
            end
            tick();
        end
    endtask

    initial begin
        int cs_fall2;
        int overlaps;
        int cs_in_recover;
        logic cs_prev;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 2'd2, wdata: 16'h1234, din: 16'h0000, exp_write: 1'b1, exp_rdata: 16'h0000};
        vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 2'd0, wdata: 16'h0000, din: 16'hBEEF, exp_write: 1'b0, exp_rdata: 16'hBEEF};
        vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 2'd1, wdata: 16'h00FF, din: 16'h5555, exp_write: 1'b1, exp_rdata: 16'hBEEF};
        vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 2'd3, wdata: 16'hA5A5, din: 16'h7777, exp_write: 1'b1, exp_rdata: 16'hBEEF};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 2'd1, wdata: 16'hFFFF, din: 16'h1357, exp_write: 1'b0, exp_rdata: 16'h1357};
        vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 2'd3, wdata: 16'h0000, din: 16'h0000, exp_write: 1'b0, exp_rdata: 16'h0000};

        // Reset, then 20 idle cycles at reset values.
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rst_cs_n",  c, {31'd0, hpi_cs_n},  32'd1);
            check("rst_rd_n",  c, {31'd0, hpi_rd_n},  32'd1);
            check("rst_wr_n",  c, {31'd0, hpi_wr_n},  32'd1);
            check("rst_oe",    c, {31'd0, hpi_data_oe}, 32'd0);
            check("rst_addr",  c, {30'd0, hpi_addr},  32'd0);
            check("rst_dout",  c, {16'd0, hpi_data_out}, 32'd0);
            check("rst_rdata", c, {16'd0, avs_readdata}, 32'd0);
            check("rst_busy",  c, {31'd0, busy}, 32'd0);
            check("rst_wait",  c, {31'd0, avs_waitrequest}, 32'd0);
            tick();
        end

        // Single-transfer vectors.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        // Back-to-back: write held to DONE, then a read held continuously.
        cs_fall2      = -1;
        overlaps      = 0;
        cs_in_recover = 0;
        cs_prev       = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            if (c == 0) begin
                avs_chipselect = 1'b1;
                avs_write      = 1'b1;
                avs_read       = 1'b0;
                avs_address    = 2'd2;
                avs_writedata  = 16'h1111;
            end
            if (c == 8) begin
                avs_write   = 1'b0;
                avs_read    = 1'b1;
                avs_address = 2'd0;
            end
            if (c == 18) begin
                idle_inputs();
            end
            hpi_data_in = (c >= 8) ? 16'h4242 : 16'h0000;
            @(negedge clk);
            if (!hpi_rd_n && !hpi_wr_n) overlaps++;
            if (c >= 7 && c <= 10 && !hpi_cs_n) cs_in_recover++;
            if (c >= 8 && cs_prev && !hpi_cs_n && cs_fall2 < 0) cs_fall2 = c;
            cs_prev = hpi_cs_n;
            if (c == 7)  check("b2b_done1_wait", c, {31'd0, avs_waitrequest}, 32'd0);
            if (c == 9)  check("b2b_recover_wait", c, {31'd0, avs_waitrequest}, 32'd1);
            if (c == 17) check("b2b_done2_wait", c, {31'd0, avs_waitrequest}, 32'd0);
            if (c == 17) check("b2b_readdata", c, {16'd0, avs_readdata}, 32'h4242);
            tick();
        end
        check("b2b_cs_fall", 0, cs_fall2, 32'd11);
        check("b2b_fall_not_early", 0, {31'd0, (cs_fall2 >= 10)}, 32'd1);
        check("b2b_strobe_overlap", 0, overlaps, 32'd0);
        check("b2b_cs_in_recover", 0, cs_in_recover, 32'd0);

        // Reset pulsed in cycle 3 of a write, then a normal read.
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) begin
                avs_chipselect = 1'b1;
                avs_write      = 1'b1;
                avs_read       = 1'b0;
                avs_address    = 2'd2;
                avs_writedata  = 16'h2222;
            end
            if (c == 3) reset_n = 1'b0;
            if (c == 4) begin
                reset_n = 1'b1;
                idle_inputs();
            end
            @(negedge clk);
            if (c == 3) begin
                check("mid_wr_n_before", c, {31'd0, hpi_wr_n}, 32'd0);
            end
            if (c >= 4) begin
                check("mid_cs_n",  c, {31'd0, hpi_cs_n}, 32'd1);
                check("mid_wr_n",  c, {31'd0, hpi_wr_n}, 32'd1);
                check("mid_oe",    c, {31'd0, hpi_data_oe}, 32'd0);
                check("mid_busy",  c, {31'd0, busy}, 32'd0);
                check("mid_rdata", c, {16'd0, avs_readdata}, 32'd0);
            end
            tick();
        end
        run_txn('{rd: 1'b1, wr: 1'b0, addr: 2'd0, wdata: 16'h0000, din: 16'h0F0F, exp_write: 1'b0, exp_rdata: 16'h0F0F});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
